// File: rtl/pipeline_mem_stage.sv
// rtl/pipeline_mem_stage.sv - RV64 memory-access stage: request/ack data port, store lanes, load align/extend, MEM->WB register
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   *_MEM          : EX->MEM pipeline register outputs (instruction in MEM)
//   dmem_*         : request/acknowledge data-memory port (registered request, one ack per request)
//   stall_MEM      : combinational, freezes IF/ID/EX while an access is pending
//   *_WB           : registered MEM->WB boundary
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to turn misaligned accesses into a
// one-cycle misalign_WB flag instead of performing them at the aligned-down offset.
module pipeline_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_MEM,
    input  logic        rf_wr_en_MEM,
    input  logic [1:0]  rf_wr_sel_MEM,
    input  logic [63:0] alu_result_MEM,
    input  logic [2:0]  dm_rd_ctrl_MEM,
    input  logic [2:0]  dm_wr_ctrl_MEM,
    input  logic [63:0] reg_data2_MEM,
    input  logic [4:0]  rd_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall_MEM,
    output logic [63:0] pc_WB,
    output logic        rf_wr_en_WB,
    output logic [1:0]  rf_wr_sel_WB,
    output logic [4:0]  rd_WB,
    output logic [63:0] alu_result_WB,
    output logic [63:0] dm_rdata_WB,
    output logic        misalign_WB
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]  state;
    logic        is_store;
    logic        is_load;
    logic        mem_op;
    logic        issue;
    logic        trap;
    logic [1:0]  size_log2;
    logic [2:0]  align_mask;
    logic [2:0]  off_al;
    logic [63:0] st_wdata;
    logic [7:0]  st_wstrb;
    logic [2:0]  ld_ctrl_q;
    logic [2:0]  ld_off_q;
    logic [63:0] ld_shifted;
    logic [63:0] ld_ext;

    // Store wins when both controls are set; store codes 5-7 mean no store.
    assign is_store = (dm_wr_ctrl_MEM != 3'd0) && (dm_wr_ctrl_MEM <= 3'd4);
    assign is_load  = !is_store && (dm_rd_ctrl_MEM != 3'd0);
    assign mem_op   = is_store || is_load;

    always_comb begin
        size_log2 = 2'd0;
        if (is_store) begin
            size_log2 = 2'(dm_wr_ctrl_MEM - 3'd1);
        end else begin
            case (dm_rd_ctrl_MEM)
                3'd3, 3'd4: size_log2 = 2'd1;
                3'd5, 3'd6: size_log2 = 2'd2;
                3'd7:       size_log2 = 2'd3;
                default:    size_log2 = 2'd0;
            endcase
        end
    end

    always_comb begin
        case (size_log2)
            2'd0:    align_mask = 3'b111;
            2'd1:    align_mask = 3'b110;
            2'd2:    align_mask = 3'b100;
            default: align_mask = 3'b000;
        endcase
    end

    // Offset forced down to the access size; only differs from the raw
    // offset for misaligned accesses.
    assign off_al = alu_result_MEM[2:0] & align_mask;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op && ((alu_result_MEM[2:0] & ~align_mask) != 3'd0);
`else
    assign trap = 1'b0;
`endif

    assign issue = mem_op && !trap;

    always_comb begin
        st_wdata = 64'd0;
        st_wstrb = 8'd0;
        if (is_store) begin
            case (dm_wr_ctrl_MEM)
                3'd1: begin
                    st_wdata = {8{reg_data2_MEM[7:0]}};
                    st_wstrb = 8'h01 << off_al;
                end
                3'd2: begin
                    st_wdata = {4{reg_data2_MEM[15:0]}};
                    st_wstrb = 8'h03 << off_al;
                end
                3'd3: begin
                    st_wdata = {2{reg_data2_MEM[31:0]}};
                    st_wstrb = 8'h0F << off_al;
                end
                default: begin
                    st_wdata = reg_data2_MEM;
                    st_wstrb = 8'hFF;
                end
            endcase
        end
    end

    assign ld_shifted = dmem_rdata >> {ld_off_q, 3'b000};

    // ld_ctrl_q is 0 for stores, which yields zero write-back data.
    always_comb begin
        case (ld_ctrl_q)
            3'd1:    ld_ext = {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            3'd2:    ld_ext = {56'd0, ld_shifted[7:0]};
            3'd3:    ld_ext = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            3'd4:    ld_ext = {48'd0, ld_shifted[15:0]};
            3'd5:    ld_ext = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            3'd6:    ld_ext = {32'd0, ld_shifted[31:0]};
            3'd7:    ld_ext = ld_shifted;
            default: ld_ext = 64'd0;
        endcase
    end

    // Gated by reset so the stall drops the instant reset asserts.
    assign stall_MEM = reset && (((state == IDLE) && issue) ||
                                 ((state == REQ) && !dmem_ack));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 64'd0;
            dmem_wdata    <= 64'd0;
            dmem_wstrb    <= 8'd0;
            ld_ctrl_q     <= 3'd0;
            ld_off_q      <= 3'd0;
            pc_WB         <= 64'd0;
            rf_wr_en_WB   <= 1'b0;
            rf_wr_sel_WB  <= 2'd0;
            rd_WB         <= 5'd0;
            alu_result_WB <= 64'd0;
            dm_rdata_WB   <= 64'd0;
            misalign_WB   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state       <= REQ;
                        dmem_req    <= 1'b1;
                        dmem_we     <= is_store;
                        dmem_addr   <= {alu_result_MEM[63:3], 3'b000};
                        dmem_wdata  <= st_wdata;
                        dmem_wstrb  <= st_wstrb;
                        ld_ctrl_q   <= is_load ? dm_rd_ctrl_MEM : 3'd0;
                        ld_off_q    <= off_al;
                        rf_wr_en_WB <= 1'b0;
                        misalign_WB <= 1'b0;
                    end else if (trap) begin
                        pc_WB         <= pc_MEM;
                        rd_WB         <= rd_MEM;
                        alu_result_WB <= alu_result_MEM;
                        rf_wr_en_WB   <= 1'b0;
                        misalign_WB   <= 1'b1;
                    end else begin
                        pc_WB         <= pc_MEM;
                        rf_wr_en_WB   <= rf_wr_en_MEM;
                        rf_wr_sel_WB  <= rf_wr_sel_MEM;
                        rd_WB         <= rd_MEM;
                        alu_result_WB <= alu_result_MEM;
                        dm_rdata_WB   <= 64'd0;
                        misalign_WB   <= 1'b0;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state         <= IDLE;
                        dmem_req      <= 1'b0;
                        pc_WB         <= pc_MEM;
                        rf_wr_en_WB   <= rf_wr_en_MEM;
                        rf_wr_sel_WB  <= rf_wr_sel_MEM;
                        rd_WB         <= rd_MEM;
                        alu_result_WB <= alu_result_MEM;
                        dm_rdata_WB   <= ld_ext;
                        misalign_WB   <= 1'b0;
                    end else begin
                        rf_wr_en_WB <= 1'b0;
                        misalign_WB <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// tb/tb_pipeline_mem_stage.sv - randomized self-checking bench for pipeline_mem_stage
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_MEM;
    logic        rf_wr_en_MEM;
    logic [1:0]  rf_wr_sel_MEM;
    logic [63:0] alu_result_MEM;
    logic [2:0]  dm_rd_ctrl_MEM;
    logic [2:0]  dm_wr_ctrl_MEM;
    logic [63:0] reg_data2_MEM;
    logic [4:0]  rd_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        stall_MEM;
    logic [63:0] pc_WB;
    logic        rf_wr_en_WB;
    logic [1:0]  rf_wr_sel_WB;
    logic [4:0]  rd_WB;
    logic [63:0] alu_result_WB;
    logic [63:0] dm_rdata_WB;
    logic        misalign_WB;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_mem_stage dut (
        .clk(clk), .reset(reset), .pc_MEM(pc_MEM), .rf_wr_en_MEM(rf_wr_en_MEM),
        .rf_wr_sel_MEM(rf_wr_sel_MEM), .alu_result_MEM(alu_result_MEM),
        .dm_rd_ctrl_MEM(dm_rd_ctrl_MEM), .dm_wr_ctrl_MEM(dm_wr_ctrl_MEM),
        .reg_data2_MEM(reg_data2_MEM), .rd_MEM(rd_MEM), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_MEM(stall_MEM), .pc_WB(pc_WB), .rf_wr_en_WB(rf_wr_en_WB),
        .rf_wr_sel_WB(rf_wr_sel_WB), .rd_WB(rd_WB), .alu_result_WB(alu_result_WB),
        .dm_rdata_WB(dm_rdata_WB), .misalign_WB(misalign_WB)
    );

    // ---------------- reference model ----------------
    function automatic bit model_is_store(input logic [2:0] wrc);
        return (wrc >= 3'd1) && (wrc <= 3'd4);
    endfunction

    function automatic int model_bytes(input logic [2:0] rdc, input logic [2:0] wrc);
        if (model_is_store(wrc)) return 1 << (int'(wrc) - 1);
        if (rdc == 3'd7) return 8;
        if (rdc >= 3'd5) return 4;
        if (rdc >= 3'd3) return 2;
        return 1;
    endfunction

    function automatic int model_offset(input int n, input logic [63:0] addr);
        int o;
        o = int'(addr % 8);
        return o - (o % n);
    endfunction

    function automatic logic [7:0] model_wstrb(input int n, input logic [63:0] addr);
        int s;
        s = ((1 << n) - 1) << model_offset(n, addr);
        return s[7:0];
    endfunction

    function automatic logic [63:0] model_wdata(input int n, input logic [63:0] data);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = data[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] rdc, input logic [63:0] addr,
                                               input logic [63:0] rdata);
        int n;
        logic [63:0] v, m;
        n = model_bytes(rdc, 3'd0);
        v = rdata >> (8 * model_offset(n, addr));
        if (n < 8) begin
            m = (64'd1 << (8 * n)) - 64'd1;
            v = v & m;
            if ((rdc == 3'd1 || rdc == 3'd3 || rdc == 3'd5) && v[8*n-1]) v = v | ~m;
        end
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_nop(input logic wren);
        pc_MEM = 64'd0; rf_wr_en_MEM = wren; rf_wr_sel_MEM = 2'd0; alu_result_MEM = 64'd0;
        dm_rd_ctrl_MEM = 3'd0; dm_wr_ctrl_MEM = 3'd0; reg_data2_MEM = 64'd0; rd_MEM = 5'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 64'd0;
        drive_nop(1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== '0) begin
            errors++; $display("FAIL reset_dmem: got req=%0b addr=%h strb=%h expected all zero", dmem_req, dmem_addr, dmem_wstrb);
        end
        checks++;
        if ({pc_WB, rf_wr_en_WB, rf_wr_sel_WB, rd_WB, alu_result_WB, dm_rdata_WB, misalign_WB} !== '0) begin
            errors++; $display("FAIL reset_wb: got pc=%h en=%0b rd=%0d alu=%h expected all zero", pc_WB, rf_wr_en_WB, rd_WB, alu_result_WB);
        end
        checks++;
        if (stall_MEM !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %0b expected 0", stall_MEM);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_passthrough(input logic [63:0] alu, input logic [4:0] rd,
                                    input logic wren, input logic [2:0] wrc);
        logic [63:0] pc;
        pc = {$urandom, $urandom};
        @(negedge clk);
        pc_MEM = pc; rf_wr_en_MEM = wren; rf_wr_sel_MEM = 2'd2; alu_result_MEM = alu;
        dm_rd_ctrl_MEM = 3'd0; dm_wr_ctrl_MEM = wrc; reg_data2_MEM = {$urandom, $urandom}; rd_MEM = rd;
        #1;
        checks++;
        if (stall_MEM !== 1'b0) begin
            errors++; $display("FAIL pass_stall: got %0b expected 0", stall_MEM);
        end
        @(posedge clk); #1;
        checks++;
        if (alu_result_WB !== alu || rd_WB !== rd || pc_WB !== pc || rf_wr_en_WB !== wren ||
            rf_wr_sel_WB !== 2'd2 || dm_rdata_WB !== 64'd0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL pass_wb: got alu=%h rd=%0d pc=%h en=%0b rdata=%h req=%0b expected alu=%h rd=%0d pc=%h en=%0b rdata=0 req=0",
                     alu_result_WB, rd_WB, pc_WB, rf_wr_en_WB, dm_rdata_WB, dmem_req, alu, rd, pc, wren);
        end
    endtask

    task automatic test_mem_op(input logic [2:0] rdc, input logic [2:0] wrc, input logic [63:0] addr,
                               input logic [63:0] data, input logic [63:0] rdata, input int waits);
        bit st;
        int n;
        logic [63:0] pc, exp_rd;
        logic [4:0] rd;
        st = model_is_store(wrc);
        n = model_bytes(rdc, wrc);
        pc = {$urandom, $urandom};
        rd = 5'($urandom);
        exp_rd = st ? 64'd0 : model_load(rdc, addr, rdata);
        @(negedge clk);
        pc_MEM = pc; rf_wr_en_MEM = !st; rf_wr_sel_MEM = st ? 2'd0 : 2'd1; alu_result_MEM = addr;
        dm_rd_ctrl_MEM = rdc; dm_wr_ctrl_MEM = wrc; reg_data2_MEM = data; rd_MEM = rd;
        dmem_ack = 1'b0;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        if ((int'(addr % 8) % n) != 0) begin
            checks++;
            if (stall_MEM !== 1'b0) begin
                errors++; $display("FAIL mis_stall: got %0b expected 0", stall_MEM);
            end
            @(posedge clk); #1;
            checks++;
            if (dmem_req !== 1'b0 || misalign_WB !== 1'b1 || rf_wr_en_WB !== 1'b0 ||
                alu_result_WB !== addr || pc_WB !== pc || rd_WB !== rd) begin
                errors++;
                $display("FAIL mis_wb: got req=%0b mis=%0b en=%0b alu=%h expected req=0 mis=1 en=0 alu=%h",
                         dmem_req, misalign_WB, rf_wr_en_WB, alu_result_WB, addr);
            end
            @(negedge clk);
            drive_nop(1'b0);
            @(posedge clk); #1;
            checks++;
            if (misalign_WB !== 1'b0) begin
                errors++; $display("FAIL mis_pulse: got %0b expected 0", misalign_WB);
            end
            return;
        end
`endif
        checks++;
        if (stall_MEM !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL idle_cycle: got stall=%0b req=%0b expected stall=1 req=0", stall_MEM, dmem_req);
        end
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== {addr[63:3], 3'b000} ||
            dmem_wstrb !== (st ? model_wstrb(n, addr) : dmem_wstrb) || rf_wr_en_WB !== 1'b0) begin
            errors++;
            $display("FAIL req_payload: got req=%0b we=%0b addr=%h strb=%h en=%0b expected req=1 we=%0b addr=%h strb=%h en=0",
                     dmem_req, dmem_we, dmem_addr, dmem_wstrb, rf_wr_en_WB, st, {addr[63:3], 3'b000}, model_wstrb(n, addr));
        end
        if (st) begin
            checks++;
            if (dmem_wdata !== model_wdata(n, data)) begin
                errors++; $display("FAIL req_wdata: got %h expected %h", dmem_wdata, model_wdata(n, data));
            end
        end
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            dmem_rdata = {$urandom, $urandom};
            #1;
            checks++;
            if (stall_MEM !== 1'b1 || rf_wr_en_WB !== 1'b0 || dmem_req !== 1'b1 ||
                dmem_addr !== {addr[63:3], 3'b000}) begin
                errors++;
                $display("FAIL wait_cycle: got stall=%0b en=%0b req=%0b addr=%h expected stall=1 en=0 req=1 addr=%h",
                         stall_MEM, rf_wr_en_WB, dmem_req, dmem_addr, {addr[63:3], 3'b000});
            end
        end
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1;
        checks++;
        if (stall_MEM !== 1'b0) begin
            errors++; $display("FAIL ack_stall: got %0b expected 0", stall_MEM);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = {$urandom, $urandom};
        checks++;
        if (dmem_req !== 1'b0 || dm_rdata_WB !== exp_rd || rd_WB !== rd || pc_WB !== pc ||
            rf_wr_en_WB !== !st || alu_result_WB !== addr || misalign_WB !== 1'b0) begin
            errors++;
            $display("FAIL wb_result: got req=%0b rdata=%h rd=%0d en=%0b alu=%h expected req=0 rdata=%h rd=%0d en=%0b alu=%h",
                     dmem_req, dm_rdata_WB, rd_WB, rf_wr_en_WB, alu_result_WB, exp_rd, rd, !st, addr);
        end
    endtask

    task automatic test_directed;
        test_passthrough(64'h1234, 5'd5, 1'b1, 3'd0);
        test_mem_op(3'd1, 3'd0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0);
        checks++;
        if (dm_rdata_WB !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++; $display("FAIL lb_value: got %h expected ffffffffffffff80", dm_rdata_WB);
        end
        test_mem_op(3'd0, 3'd2, 64'h2006, 64'hABCD, 64'd0, 3);
        test_mem_op(3'd6, 3'd0, 64'h3004, 64'd0, 64'hF000_0001_0000_0000, 1);
        checks++;
        if (dm_rdata_WB !== 64'h0000_0000_F000_0001) begin
            errors++; $display("FAIL lwu_value: got %h expected 00000000f0000001", dm_rdata_WB);
        end
        test_mem_op(3'd5, 3'd0, 64'h4002, 64'd0, 64'h1111_2222_8765_4321, 0);
`ifndef MEM_MISALIGN_TRAP_EN
        checks++;
        if (dm_rdata_WB !== 64'hFFFF_FFFF_8765_4321) begin
            errors++; $display("FAIL lw_misaligned: got %h expected ffffffff87654321", dm_rdata_WB);
        end
`endif
        // Store and load both set: store wins.
        test_mem_op(3'd7, 3'd4, 64'h5000, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
    endtask

    task automatic test_back_to_back;
        test_mem_op(3'd7, 3'd0, 64'h6000, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 0);
        test_mem_op(3'd0, 3'd1, 64'h6005, 64'h77, 64'd0, 0);
        test_mem_op(3'd3, 3'd0, 64'h6002, 64'd0, 64'h0000_0000_8001_0000, 2);
    endtask

    task automatic test_random;
        logic [2:0] rdc, wrc;
        logic [63:0] addr;
        for (int k = 0; k < 60; k++) begin
            rdc = 3'($urandom_range(0, 7));
            wrc = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if (!model_is_store(wrc) && rdc == 3'd0)
                test_passthrough(addr, 5'($urandom), 1'($urandom), wrc);
            else
                test_mem_op(rdc, wrc, addr, {$urandom, $urandom}, {$urandom, $urandom},
                            int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_in_req;
        @(negedge clk);
        pc_MEM = 64'h80; rf_wr_en_MEM = 1'b1; rf_wr_sel_MEM = 2'd1; alu_result_MEM = 64'h7000;
        dm_rd_ctrl_MEM = 3'd7; dm_wr_ctrl_MEM = 3'd0; rd_MEM = 5'd9; dmem_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL rst_req_start: got %0b expected 1", dmem_req);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || stall_MEM !== 1'b0) begin
            errors++; $display("FAIL rst_abandon: got req=%0b stall=%0b expected 0 0", dmem_req, stall_MEM);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_nop(1'b0);
        dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if (rf_wr_en_WB !== 1'b0 || dm_rdata_WB !== 64'd0 || dmem_req !== 1'b0 || stall_MEM !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: got en=%0b rdata=%h req=%0b stall=%0b expected 0 0 0 0",
                     rf_wr_en_WB, dm_rdata_WB, dmem_req, stall_MEM);
        end
        test_mem_op(3'd2, 3'd0, 64'h7007, 64'd0, 64'hAB00_0000_0000_0000, 0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_random;
        test_reset_in_req;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
